mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter RR_EN, default 1: 1 = round-robin on simultaneous requests; 0 = fixed D-side priority.
REQ-002 SHALL have port clk_i, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_i, input, 1: reset, synchronous, active-high.
REQ-004 SHALL have I-side ports (fetch):
- imem_addr_i, input, ADDRW
- imem_valid_i, input, 1
- imem_rdata_o, output, DATAW
- imem_resp_o, output, 1
REQ-005 SHALL have D-side ports (load/store):
- dmem_addr_i, input, ADDRW
- dmem_wdata_i, input, DATAW
- dmem_wmask_i, input, DATAW/8
- dmem_we_i, input, 1
- dmem_valid_i, input, 1
- dmem_rdata_o, output, DATAW
- dmem_resp_o, output, 1
REQ-006 SHALL have memory ports:
- mem_addr_o, output, ADDRW
- mem_wdata_o, output, DATAW
- mem_wmask_o, output, DATAW/8
- mem_we_o, output, 1
- mem_valid_o, output, 1
- mem_rdata_i, input, DATAW
- mem_resp_i, input, 1

Function
REQ-007 SHALL use FSM states IDLE, BUSY_I, BUSY_D, with at most one outstanding memory transaction.
REQ-008 In IDLE, SHALL sample imem_valid_i and dmem_valid_i each cycle. On any request it SHALL latch the winner's addr/wdata/wmask/we and move to BUSY_I or BUSY_D on the next edge.
REQ-009 SHALL use fetch-side we=0 and wmask=0 for I-side grants.
REQ-010 On simultaneous requests with RR_EN=1, SHALL grant the side not granted last. The last-grant flag resets to I, so the first tie goes to D.
REQ-011 On simultaneous requests with RR_EN=0, SHALL always grant D.
REQ-012 mem_valid_o SHALL be 1 exactly while in BUSY_I/BUSY_D. mem_addr_o/wdata/wmask/we SHALL hold the latched values, stable until the response.
REQ-013 mem_addr_o SHALL be the latched address with bits [1:0] forced to 2'b00.
REQ-014 In BUSY_x with mem_resp_i=1, SHALL assert x_resp_o combinationally in that same cycle, drive x_rdata_o = mem_rdata_i, and return to IDLE on the next edge.
REQ-015 x_rdata_o SHALL pass mem_rdata_i through at all times; it is valid only when x_resp_o=1.
REQ-016 The non-owner resp_o SHALL be 0 in every cycle.
REQ-017 Minimum latency SHALL be: request sampled in cycle N, mem_valid_o=1 in cycle N+1, resp no earlier than N+1. The next grant SHALL be sampled no earlier than the cycle after a response.
REQ-018 Deassertion of, or an address change on, a requester's valid while BUSY SHALL NOT abort the transaction. The response SHALL still be returned to that requester for one cycle (fetch discards it).
REQ-019 mem_resp_i in IDLE SHALL be ignored: no resp_o asserted, no state change.
REQ-020 mem_resp_i coincident with a new request in IDLE SHALL still grant per REQ-008 and REQ-010.
REQ-021 Each resp_o SHALL be a single-cycle pulse per completed transaction.

Reset
REQ-022 On rst_i=1, SHALL set state=IDLE, last-grant=I, and latched request registers to 0.
REQ-023 During reset, SHALL drive mem_valid_o=0, mem_we_o=0, mem_wmask_o=0, mem_addr_o=0, mem_wdata_o=0, imem_resp_o=0, dmem_resp_o=0.
REQ-024 Reset mid-transaction SHALL drop the outstanding transaction. A later mem_resp_i for it is ignored per REQ-019.

Structure
REQ-025 orion_types SHALL add arb_state_t {IDLE, BUSY_I, BUSY_D} and arb_owner_t {OWN_I, OWN_D}. ADDRW/DATAW SHALL come from orion_types.
REQ-026 Two-requester grant logic SHALL be a sub-module rr_arbiter: inputs req[1:0], last-grant, RR_EN; output one-hot grant.

Verification
REQ-027 Reset then I-only: imem_valid_i=1, addr 0x8000_0002 -> next cycle mem_valid_o=1, mem_addr_o=0x8000_0000, mem_we_o=0. mem_resp_i with rdata 0x0000_0013 -> imem_resp_o=1, imem_rdata_o=0x0000_0013 same cycle, dmem_resp_o=0.
REQ-028 Simultaneous requests, RR_EN=1, D store addr 0x8000_1000, wdata 0xDEAD_BEEF, wmask 0xF -> D granted first (mem_we_o=1). After its response, I granted next even with D still requesting.
REQ-029 RR_EN=0, both requesting continuously for 4 transactions -> all 4 granted to D, imem_resp_o never 1.
REQ-030 I granted, then imem_addr_i changes (jump) mid-transaction -> mem_addr_o unchanged. imem_resp_o pulses once on mem_resp_i, then the new address is issued.
REQ-031 rst_i=1 in BUSY_D, then mem_resp_i=1 two cycles after reset release with no requests -> no resp_o asserted, state IDLE.

Source files
------------

// File: rtl/orion_types.sv
// Shared widths and types for the Orion core memory path.
// Bus widths, arbiter state/owner enums and the latched request record.
package orion_types;

    localparam int ADDRW = 32;
    localparam int DATAW = 32;
    localparam int MASKW = DATAW / 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } arb_owner_t;

    typedef struct packed {
        logic [ADDRW-1:0] addr;
        logic [DATAW-1:0] wdata;
        logic [MASKW-1:0] wmask;
        logic             we;
    } mem_req_t;

    // Memory is word addressed; the byte offset travels in the mask instead.
    function automatic logic [ADDRW-1:0] word_align(input logic [ADDRW-1:0] a);
        return {a[ADDRW-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Two-requester grant: bit 0 = fetch (I), bit 1 = load/store (D), one-hot grant.
// Combinational; ties alternate against the last owner when rr_en_i, else D wins.
module rr_arbiter
    import orion_types::*;
(
    input  logic [1:0]  req_i,
    input  arb_owner_t  last_i,
    input  logic        rr_en_i,
    output logic [1:0]  gnt_o
);

    always_comb begin
        gnt_o = 2'b00;
        unique case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11: begin
                if (rr_en_i && (last_i == OWN_D)) begin
                    gnt_o = 2'b01;
                end else begin
                    gnt_o = 2'b10;
                end
            end
            default: gnt_o = 2'b00;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between fetch and load/store, one transaction in flight.
// Request seen in IDLE issues next cycle; response is routed back combinationally.
module mem_arbiter
    import orion_types::*;
#(
    parameter bit RR_EN = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_i,

    input  logic [ADDRW-1:0] imem_addr_i,
    input  logic             imem_valid_i,
    output logic [DATAW-1:0] imem_rdata_o,
    output logic             imem_resp_o,

    input  logic [ADDRW-1:0] dmem_addr_i,
    input  logic [DATAW-1:0] dmem_wdata_i,
    input  logic [MASKW-1:0] dmem_wmask_i,
    input  logic             dmem_we_i,
    input  logic             dmem_valid_i,
    output logic [DATAW-1:0] dmem_rdata_o,
    output logic             dmem_resp_o,

    output logic [ADDRW-1:0] mem_addr_o,
    output logic [DATAW-1:0] mem_wdata_o,
    output logic [MASKW-1:0] mem_wmask_o,
    output logic             mem_we_o,
    output logic             mem_valid_o,
    input  logic [DATAW-1:0] mem_rdata_i,
    input  logic             mem_resp_i
);

    arb_state_t state_q, state_d;
    arb_owner_t last_q,  last_d;
    mem_req_t   req_q,   req_d;

    logic [1:0] req_vec;
    logic [1:0] gnt;
    logic       busy_i;
    logic       busy_d;

    assign req_vec = {dmem_valid_i, imem_valid_i};

    rr_arbiter u_rr_arbiter (
        .req_i   (req_vec),
        .last_i  (last_q),
        .rr_en_i (RR_EN),
        .gnt_o   (gnt)
    );

    // Requester inputs are only looked at in IDLE, so a requester dropping
    // valid or changing address mid-transaction cannot disturb it.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        req_d   = req_q;
        unique case (state_q)
            IDLE: begin
                if (gnt[1]) begin
                    state_d = BUSY_D;
                    last_d  = OWN_D;
                    req_d   = '{addr:  dmem_addr_i,
                                wdata: dmem_wdata_i,
                                wmask: dmem_wmask_i,
                                we:    dmem_we_i};
                end else if (gnt[0]) begin
                    state_d = BUSY_I;
                    last_d  = OWN_I;
                    req_d   = '{addr:  imem_addr_i,
                                wdata: '0,
                                wmask: '0,
                                we:    1'b0};
                end
            end
            BUSY_I, BUSY_D: begin
                if (mem_resp_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            last_q  <= OWN_I;
            req_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            req_q   <= req_d;
        end
    end

    assign busy_i = (state_q == BUSY_I);
    assign busy_d = (state_q == BUSY_D);

    // Reset masks the outputs immediately, before the synchronous clear lands.
    assign mem_valid_o = ~rst_i & (busy_i | busy_d);
    assign mem_addr_o  = rst_i ? '0 : word_align(req_q.addr);
    assign mem_wdata_o = rst_i ? '0 : req_q.wdata;
    assign mem_wmask_o = rst_i ? '0 : req_q.wmask;
    assign mem_we_o    = ~rst_i & req_q.we;

    assign imem_resp_o  = ~rst_i & busy_i & mem_resp_i;
    assign dmem_resp_o  = ~rst_i & busy_d & mem_resp_i;
    assign imem_rdata_o = mem_rdata_i;
    assign dmem_rdata_o = mem_rdata_i;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: round-robin (index 0) and fixed-priority (index 1) instances
// share stimulus; table vectors, directed corner sequences and random traffic vs a model.
module tb_mem_arbiter;
    import orion_types::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst, iv, dv, dwe, mresp;
    logic [ADDRW-1:0] ia, da;
    logic [DATAW-1:0] dwd, mrd;
    logic [MASKW-1:0] dwm;

    logic [DATAW-1:0] irdata [2];
    logic [DATAW-1:0] drdata [2];
    logic [DATAW-1:0] mwdata [2];
    logic [ADDRW-1:0] maddr  [2];
    logic [MASKW-1:0] mwmask [2];
    logic             mwe    [2];
    logic             mvalid [2];
    logic             iresp  [2];
    logic             dresp  [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        mem_arbiter #(.RR_EN(g == 0)) u_dut (
            .clk_i        (clk),
            .rst_i        (rst),
            .imem_addr_i  (ia),
            .imem_valid_i (iv),
            .imem_rdata_o (irdata[g]),
            .imem_resp_o  (iresp[g]),
            .dmem_addr_i  (da),
            .dmem_wdata_i (dwd),
            .dmem_wmask_i (dwm),
            .dmem_we_i    (dwe),
            .dmem_valid_i (dv),
            .dmem_rdata_o (drdata[g]),
            .dmem_resp_o  (dresp[g]),
            .mem_addr_o   (maddr[g]),
            .mem_wdata_o  (mwdata[g]),
            .mem_wmask_o  (mwmask[g]),
            .mem_we_o     (mwe[g]),
            .mem_valid_o  (mvalid[g]),
            .mem_rdata_i  (mrd),
            .mem_resp_i   (mresp)
        );
    end

    // Transaction-level view of each arbiter: is something outstanding, for whom, with what.
    typedef struct {
        bit          busy;
        bit          own_d;
        bit          last_d;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        bit          we;
    } mdl_t;

    mdl_t m [2];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_check();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("mem_valid[%0d]", k), mvalid[k], !rst && m[k].busy);
            chk($sformatf("mem_addr[%0d]", k), maddr[k], rst ? 32'h0 : {m[k].addr[31:2], 2'b00});
            chk($sformatf("mem_wdata[%0d]", k), mwdata[k], rst ? 32'h0 : m[k].wdata);
            chk($sformatf("mem_wmask[%0d]", k), mwmask[k], rst ? 4'h0 : m[k].wmask);
            chk($sformatf("mem_we[%0d]", k), mwe[k], !rst && m[k].we);
            chk($sformatf("imem_resp[%0d]", k), iresp[k], !rst && m[k].busy && !m[k].own_d && mresp);
            chk($sformatf("dmem_resp[%0d]", k), dresp[k], !rst && m[k].busy && m[k].own_d && mresp);
            chk($sformatf("imem_rdata[%0d]", k), irdata[k], mrd);
            chk($sformatf("dmem_rdata[%0d]", k), drdata[k], mrd);
        end
    endtask

    task automatic model_update();
        bit pick_d;
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m[k] = '{default: '0};
            end else if (m[k].busy) begin
                if (mresp) m[k].busy = 1'b0;
            end else if (iv || dv) begin
                // k==0 alternates on a tie starting with D; k==1 always prefers D.
                pick_d = dv && (!iv || (k == 1) || !m[k].last_d);
                m[k].busy   = 1'b1;
                m[k].own_d  = pick_d;
                m[k].last_d = pick_d;
                m[k].addr   = pick_d ? da  : ia;
                m[k].wdata  = pick_d ? dwd : 32'h0;
                m[k].wmask  = pick_d ? dwm : 4'h0;
                m[k].we     = pick_d ? dwe : 1'b0;
            end
        end
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic advance();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic step();
        settle();
        model_check();
        advance();
    endtask

    task automatic drain();
        rst = 0; iv = 0; dv = 0; dwe = 0; mresp = 1;
        step();
        mresp = 0;
        step();
    endtask

    typedef struct {
        bit          rst, iv;
        logic [31:0] ia;
        bit          dv;
        logic [31:0] da, dwd;
        logic [3:0]  dwm;
        bit          dwe, mresp;
        logic [31:0] mrd;
        bit          e_mv;
        logic [31:0] e_ma;
        bit          e_we, e_ir, e_dr;
    } vec_t;

    function automatic vec_t mk(bit r, bit i_v, logic [31:0] i_a, bit d_v, logic [31:0] d_a,
                                logic [31:0] d_wd, logic [3:0] d_wm, bit d_we, bit m_r,
                                logic [31:0] m_rd, bit e_mv, logic [31:0] e_ma, bit e_we,
                                bit e_ir, bit e_dr);
        vec_t v;
        v = '{r, i_v, i_a, d_v, d_a, d_wd, d_wm, d_we, m_r, m_rd, e_mv, e_ma, e_we, e_ir, e_dr};
        return v;
    endfunction

    vec_t tbl [13];

    initial begin
        int dcnt, icnt, cyc;

        rst = 1; iv = 0; dv = 0; dwe = 0; mresp = 0;
        ia = '0; da = '0; dwd = '0; dwm = '0; mrd = '0;
        m[0] = '{default: '0};
        m[1] = '{default: '0};

        //            rst iv ia            dv da            wdata         wm   we rsp rdata         mv ma            we ir dr
        tbl[0]  = mk(1, 0, 32'h0,        0, 32'h0,        32'h0,        4'h0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 0);
        tbl[1]  = mk(1, 0, 32'h0,        0, 32'h0,        32'h0,        4'h0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 0);
        tbl[2]  = mk(0, 1, 32'h80000002, 0, 32'h0,        32'h0,        4'h0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 0);
        tbl[3]  = mk(0, 1, 32'h80000002, 0, 32'h0,        32'h0,        4'h0, 0, 0, 32'h0,        1, 32'h80000000, 0, 0, 0);
        tbl[4]  = mk(0, 1, 32'h80000002, 0, 32'h0,        32'h0,        4'h0, 0, 1, 32'h00000013, 1, 32'h80000000, 0, 1, 0);
        tbl[5]  = mk(0, 0, 32'h0,        0, 32'h0,        32'h0,        4'h0, 0, 0, 32'h0,        0, 32'h80000000, 0, 0, 0);
        tbl[6]  = mk(0, 1, 32'h80000100, 1, 32'h80001000, 32'hDEADBEEF, 4'hF, 1, 0, 32'h0,        0, 32'h80000000, 0, 0, 0);
        tbl[7]  = mk(0, 1, 32'h80000100, 1, 32'h80001000, 32'hDEADBEEF, 4'hF, 1, 0, 32'h0,        1, 32'h80001000, 1, 0, 0);
        tbl[8]  = mk(0, 1, 32'h80000100, 1, 32'h80001000, 32'hDEADBEEF, 4'hF, 1, 1, 32'h0,        1, 32'h80001000, 1, 0, 1);
        tbl[9]  = mk(0, 1, 32'h80000100, 1, 32'h80001000, 32'hDEADBEEF, 4'hF, 1, 0, 32'h0,        0, 32'h80001000, 1, 0, 0);
        tbl[10] = mk(0, 1, 32'h80000100, 1, 32'h80001000, 32'hDEADBEEF, 4'hF, 1, 0, 32'h0,        1, 32'h80000100, 0, 0, 0);
        tbl[11] = mk(0, 1, 32'h80000100, 1, 32'h80001000, 32'hDEADBEEF, 4'hF, 1, 1, 32'h00001234, 1, 32'h80000100, 0, 1, 0);
        tbl[12] = mk(0, 0, 32'h0,        0, 32'h0,        32'h0,        4'h0, 0, 0, 32'h0,        0, 32'h80000100, 0, 0, 0);

        for (int i = 0; i < 13; i++) begin
            rst = tbl[i].rst; iv = tbl[i].iv; ia = tbl[i].ia;
            dv = tbl[i].dv; da = tbl[i].da; dwd = tbl[i].dwd; dwm = tbl[i].dwm;
            dwe = tbl[i].dwe; mresp = tbl[i].mresp; mrd = tbl[i].mrd;
            settle();
            chk($sformatf("tbl%0d_mem_valid", i), mvalid[0], tbl[i].e_mv);
            chk($sformatf("tbl%0d_mem_addr", i), maddr[0], tbl[i].e_ma);
            chk($sformatf("tbl%0d_mem_we", i), mwe[0], tbl[i].e_we);
            chk($sformatf("tbl%0d_imem_resp", i), iresp[0], tbl[i].e_ir);
            chk($sformatf("tbl%0d_dmem_resp", i), dresp[0], tbl[i].e_dr);
            if (tbl[i].e_ir) chk($sformatf("tbl%0d_imem_rdata", i), irdata[0], tbl[i].mrd);
            model_check();
            advance();
        end

        // Fixed priority: both sides hold valid; D must win every time.
        drain();
        iv = 1; ia = 32'h80000040; dv = 1; da = 32'h80003000; dwd = 32'h11223344; dwm = 4'h3; dwe = 1;
        dcnt = 0; icnt = 0; cyc = 0;
        while (dcnt < 4 && cyc < 40) begin
            mresp = mvalid[1];
            mrd = $urandom;
            settle();
            model_check();
            if (dresp[1]) dcnt++;
            if (iresp[1]) icnt++;
            advance();
            cyc++;
        end
        chk("fixed_prio_d_grants", dcnt, 4);
        chk("fixed_prio_no_imem_resp", icnt, 0);
        iv = 0; dv = 0; mresp = 0;

        // Fetch jump while its transaction is outstanding.
        drain();
        iv = 1; ia = 32'h80000204;
        step();
        ia = 32'h80000400;
        settle(); model_check();
        chk("jump_addr_hold", maddr[0], 32'h80000204);
        advance();
        settle(); model_check();
        chk("jump_addr_hold2", maddr[0], 32'h80000204);
        advance();
        mresp = 1; mrd = 32'hCAFE0001;
        settle(); model_check();
        chk("jump_imem_resp", iresp[0], 1);
        chk("jump_imem_rdata", irdata[0], 32'hCAFE0001);
        advance();
        mresp = 0;
        settle(); model_check();
        chk("jump_resp_single_pulse", iresp[0], 0);
        chk("jump_idle_gap", mvalid[0], 0);
        advance();
        settle(); model_check();
        chk("jump_new_valid", mvalid[0], 1);
        chk("jump_new_addr", maddr[0], 32'h80000400);
        advance();
        iv = 0;

        // Reset while a D transaction is outstanding; a late response must be ignored.
        drain();
        dv = 1; da = 32'h80002000; dwe = 0; dwm = 4'hF;
        step();
        dv = 0;
        settle(); model_check();
        chk("rst_pre_busy", mvalid[0], 1);
        advance();
        rst = 1; mresp = 1;
        settle(); model_check();
        chk("rst_mem_valid", mvalid[0], 0);
        chk("rst_dmem_resp", dresp[0], 0);
        chk("rst_mem_addr", maddr[0], 32'h0);
        advance();
        rst = 0; mresp = 0;
        step();
        step();
        mresp = 1;
        settle(); model_check();
        chk("late_resp_dmem", dresp[0], 0);
        chk("late_resp_imem", iresp[0], 0);
        chk("late_resp_valid", mvalid[0], 0);
        advance();
        mresp = 0;
        settle(); model_check();
        chk("late_resp_still_idle", mvalid[0], 0);
        advance();

        // Random traffic checked cycle by cycle against the model.
        for (int c = 0; c < 1500; c++) begin
            rst   = ($urandom_range(0, 99) == 0);
            iv    = ($urandom_range(0, 2) != 0);
            dv    = ($urandom_range(0, 2) != 0);
            ia    = $urandom;
            da    = $urandom;
            dwd   = $urandom;
            dwm   = 4'($urandom);
            dwe   = 1'($urandom);
            mresp = ($urandom_range(0, 2) == 0);
            mrd   = $urandom;
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
